// File: rtl/sram_rd_sched_if.sv
// sram_rd_sched_if: queue status inputs and read-engine handshake for one output-port scheduler.
interface sram_rd_sched_if #(
   parameter int num_of_priority = 8,
   parameter int pri_width = $clog2(num_of_priority)
);
   logic [num_of_priority-1:0] q_nonempty, ready;
   logic mode, deq_ack, beat_vld, beat_eop;
   logic deq_req, busy, err_stray;
   logic [pri_width-1:0] deq_pri;
   logic [15:0] beat_cnt;
   modport master (
      output q_nonempty, ready, mode, deq_ack, beat_vld, beat_eop,
      input deq_req, deq_pri, busy, beat_cnt, err_stray
   );
   modport slave (
      input q_nonempty, ready, mode, deq_ack, beat_vld, beat_eop,
      output deq_req, deq_pri, busy, beat_cnt, err_stray
   );
endinterface

// File: rtl/sram_rd_sched.sv
// sram_rd_sched: per-output-port dequeue scheduler, strict priority with aging or round-robin,
// holding each grant until the packet's last beat has been read.
module sram_rd_sched #(
   parameter int num_of_priority = 8,
   parameter int pri_width = $clog2(num_of_priority),
   parameter int starve_limit = 15,
   parameter int cnt_width = $clog2(starve_limit + 1)
) (
   input logic clk,
   input logic rst_n,
   sram_rd_sched_if.slave io
);
   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
   state_t state_q;
   logic deq_req_q, busy_q, err_stray_q;
   logic [pri_width-1:0] deq_pri_q, rr_q, rr_d, win_s, win_r, win;
   logic [15:0] beat_cnt_q;
   logic [cnt_width-1:0] age_q [num_of_priority];
   logic [cnt_width-1:0] age_d [num_of_priority];
   logic [num_of_priority-1:0] elig, starved, pool;
   int j;
   assign elig = io.q_nonempty & io.ready;
   always_comb begin
      starved = '0;
      win_s = '0;
      win_r = '0;
      j = 0;
      for (int i = 0; i < num_of_priority; i++)
         starved[i] = elig[i] && (age_q[i] == cnt_width'(starve_limit));
      pool = |starved ? starved : elig;
      for (int i = 0; i < num_of_priority; i++)
         if (pool[i]) win_s = pri_width'(i);
      // descending offset so the nearest eligible queue at or after rr_q is written last
      for (int i = num_of_priority - 1; i >= 0; i--) begin
         j = int'(rr_q) + i;
         j = (j >= num_of_priority) ? j - num_of_priority : j;
         if (elig[pri_width'(j)]) win_r = pri_width'(j);
      end
      win = io.mode ? win_r : win_s;
      rr_d = (win == pri_width'(num_of_priority - 1)) ? '0 : win + pri_width'(1);
      for (int i = 0; i < num_of_priority; i++)
         age_d[i] = (pri_width'(i) == win) ? '0 :
                    (elig[i] && age_q[i] != cnt_width'(starve_limit)) ? age_q[i] + cnt_width'(1) : age_q[i];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         deq_req_q <= 1'b0;
         deq_pri_q <= '0;
         busy_q <= 1'b0;
         beat_cnt_q <= '0;
         err_stray_q <= 1'b0;
         rr_q <= '0;
         age_q <= '{default: '0};
      end else begin
         if (io.beat_vld && state_q != XFER) err_stray_q <= 1'b1;
         case (state_q)
            IDLE: if (|elig) begin
               deq_pri_q <= win;
               deq_req_q <= 1'b1;
               busy_q <= 1'b1;
               beat_cnt_q <= '0;
               age_q <= age_d;
               if (io.mode) rr_q <= rr_d;
               state_q <= REQ;
            end
            REQ: if (io.deq_ack) begin
               deq_req_q <= 1'b0;
               state_q <= XFER;
            end
            XFER: if (io.beat_vld) begin
               beat_cnt_q <= beat_cnt_q + ((beat_cnt_q != 16'hFFFF) ? 16'd1 : 16'd0);
               if (io.beat_eop) begin
                  busy_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign io.deq_req = deq_req_q;
   assign io.deq_pri = deq_pri_q;
   assign io.busy = busy_q;
   assign io.beat_cnt = beat_cnt_q;
   assign io.err_stray = err_stray_q;
endmodule

// File: tb/tb_sram_rd_sched.sv
// tb_sram_rd_sched: directed stimulus with a grant/beat-count scoreboard checked by a negedge monitor.
module tb_sram_rd_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   int exp_pri[$];
   int exp_cnt[$];
   logic req_prev = 1'b0;
   logic busy_prev = 1'b0;
   sram_rd_sched_if #(.num_of_priority(8)) io ();
   sram_rd_sched dut (.clk(clk), .rst_n(rst_n), .io(io.slave));
   always #5 clk = ~clk;
   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction
   always @(negedge clk) begin
      if (rst_n && io.deq_req && !req_prev) begin
         chk("grant_expected", int'(exp_pri.size() > 0), 1);
         if (exp_pri.size() > 0) chk("grant_pri", int'(io.deq_pri), exp_pri.pop_front());
      end
      if (rst_n && !io.busy && busy_prev) begin
         chk("done_expected", int'(exp_cnt.size() > 0), 1);
         if (exp_cnt.size() > 0) chk("beat_cnt", int'(io.beat_cnt), exp_cnt.pop_front());
      end
      req_prev = io.deq_req;
      busy_prev = io.busy;
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic expect_pkt(input int pri, input int beats);
      exp_pri.push_back(pri);
      exp_cnt.push_back(beats);
   endtask
   task automatic serve(input int beats);
      int t = 0;
      while (!io.deq_req && t < 40) begin
         step();
         t++;
      end
      chk("req_seen", int'(io.deq_req), 1);
      if (!io.deq_req) return;
      io.deq_ack = 1'b1;
      step();
      io.deq_ack = 1'b0;
      for (int b = 1; b <= beats; b++) begin
         io.beat_vld = 1'b1;
         io.beat_eop = (b == beats);
         step();
      end
      io.beat_vld = 1'b0;
      io.beat_eop = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      io.q_nonempty = '0;
      io.ready = '0;
      io.mode = 1'b0;
      io.deq_ack = 1'b0;
      io.beat_vld = 1'b0;
      io.beat_eop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_deq_req", int'(io.deq_req), 0);
      chk("rst_deq_pri", int'(io.deq_pri), 0);
      chk("rst_busy", int'(io.busy), 0);
      chk("rst_beat_cnt", int'(io.beat_cnt), 0);
      chk("rst_err_stray", int'(io.err_stray), 0);
      rst_n = 1'b1;
      step();
      // single eligible queue, 4-beat packet
      expect_pkt(2, 4);
      io.q_nonempty = 8'h04;
      io.ready = 8'h04;
      chk("idle_no_req", int'(io.deq_req), 0);
      step();
      chk("req_latency", int'(io.deq_req), 1);
      chk("busy_in_req", int'(io.busy), 1);
      serve(4);
      io.q_nonempty = '0;
      io.ready = '0;
      chk("busy_after_eop", int'(io.busy), 0);
      chk("beat_cnt_4", int'(io.beat_cnt), 4);
      step();
      step();
      // q0 must be forced after 15 grants to q7
      for (int k = 0; k < 15; k++) expect_pkt(7, 1);
      expect_pkt(0, 1);
      io.q_nonempty = 8'h81;
      io.ready = 8'h81;
      for (int k = 0; k < 16; k++) serve(1);
      io.q_nonempty = '0;
      io.ready = '0;
      chk("age0_after_force", int'(dut.age_q[0]), 0);
      chk("age7_after_force", int'(dut.age_q[7]), 1);
      step();
      step();
      // round-robin sweep from rr_ptr=0
      io.mode = 1'b1;
      for (int k = 0; k < 9; k++) expect_pkt(k % 8, 1);
      io.q_nonempty = 8'hFF;
      io.ready = 8'hFF;
      for (int k = 0; k < 9; k++) serve(1);
      io.q_nonempty = '0;
      io.ready = '0;
      io.mode = 1'b0;
      step();
      step();
      // request held through eligibility loss and a delayed ack
      expect_pkt(4, 2);
      io.q_nonempty = 8'h10;
      io.ready = 8'h10;
      step();
      io.ready = '0;
      for (int k = 0; k < 5; k++) begin
         chk("hold_req", int'(io.deq_req), 1);
         chk("hold_pri", int'(io.deq_pri), 4);
         step();
      end
      io.deq_ack = 1'b1;
      step();
      io.deq_ack = 1'b0;
      chk("req_drop_after_ack", int'(io.deq_req), 0);
      chk("busy_in_xfer", int'(io.busy), 1);
      io.beat_eop = 1'b1;
      step();
      io.beat_eop = 1'b0;
      chk("eop_without_vld", int'(io.busy), 1);
      io.beat_vld = 1'b1;
      step();
      io.beat_eop = 1'b1;
      step();
      io.beat_vld = 1'b0;
      io.beat_eop = 1'b0;
      io.q_nonempty = '0;
      chk("busy_done_hold", int'(io.busy), 0);
      step();
      step();
      // asynchronous reset in the middle of a transfer
      exp_pri.push_back(5);
      io.q_nonempty = 8'h20;
      io.ready = 8'h20;
      step();
      io.deq_ack = 1'b1;
      step();
      io.deq_ack = 1'b0;
      io.beat_vld = 1'b1;
      step();
      step();
      io.beat_vld = 1'b0;
      chk("cnt_before_rst", int'(io.beat_cnt), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_req", int'(io.deq_req), 0);
      chk("async_rst_busy", int'(io.busy), 0);
      chk("async_rst_cnt", int'(io.beat_cnt), 0);
      expect_pkt(5, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      serve(1);
      io.q_nonempty = '0;
      io.ready = '0;
      chk("no_stray_yet", int'(io.err_stray), 0);
      step();
      // stray beat in IDLE is sticky across later packets
      io.beat_vld = 1'b1;
      step();
      io.beat_vld = 1'b0;
      chk("err_stray_set", int'(io.err_stray), 1);
      expect_pkt(1, 3);
      io.q_nonempty = 8'h02;
      io.ready = 8'h02;
      serve(3);
      io.q_nonempty = '0;
      io.ready = '0;
      chk("err_stray_sticky", int'(io.err_stray), 1);
      step();
      step();
      chk("pending_grants", exp_pri.size(), 0);
      chk("pending_counts", exp_cnt.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sram_rd_sched.md
Name: sram_rd_sched

Overview:
- Per-output-port read scheduler for the shared-SRAM switch. One instance per output port (16 total).
- Picks which of the port's priority queues supplies the next packet, issues a dequeue request to the SRAM read engine, then holds that choice until the packet's last beat has been read.
- Two arbitration modes:
  - Strict priority, with anti-starvation aging.
  - Round-robin.
- Sits between the per-queue status logic (queue non-empty, egress ready) and the SRAM read datapath that drives rd_sop/rd_eop/rd_vld/rd_data.

Parameters:
- num_of_priority, 8, number of priority queues per output port. Index num_of_priority-1 is the highest priority.
- pri_width, $clog2(num_of_priority), width of the priority index.
- starve_limit, 15, number of grants to other queues an eligible queue may wait through before it is forced. Must be ≥ 1.
- cnt_width, $clog2(starve_limit+1), width of the aging counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset. Asynchronous assert, active-low.
- q_nonempty  input  num_of_priority  bit i = queue i holds at least one complete packet.
- ready  input  num_of_priority  bit i = egress can accept priority i.
- mode  input  1  0 = strict priority with aging, 1 = round-robin.
- deq_ack  input  1  read engine has accepted the current request.
- beat_vld  input  1  read engine is delivering a data beat of the granted packet.
- beat_eop  input  1  qualifies beat_vld as the packet's last beat.
- deq_req  output  1  dequeue request to the read engine.
- deq_pri  output  pri_width  queue index of the request. Stable while deq_req=1 and throughout the transfer.
- busy  output  1  high in REQ and XFER.
- beat_cnt  output  16  beats seen in the current or last packet. Saturates at 16'hFFFF.
- err_stray  output  1  sticky. Set on beat_vld outside XFER.

Behaviour:
- Reset values (rst_n=0, asynchronous): state=IDLE, deq_req=0, deq_pri=0, busy=0, beat_cnt=0, err_stray=0, rr_ptr=0, all aging counters=0.
- Reset mid-packet abandons the transfer. No recovery handshake is issued to the read engine.
- eligible[i] = q_nonempty[i] & ready[i]. Evaluated combinationally, but acted on only in IDLE.
- FSM IDLE:
  - If eligible≠0, choose a winner per mode.
  - Register deq_pri=winner and deq_req=1 (visible the next cycle). Clear beat_cnt. Go to REQ.
  - Otherwise stay in IDLE with deq_req=0.
  - mode is sampled only here.
- FSM REQ:
  - Hold deq_req=1 and deq_pri constant until deq_ack=1 is sampled.
  - On ack: deq_req=0 next cycle, go to XFER.
  - The request is never withdrawn, even if eligible[deq_pri] drops.
  - deq_ack outside REQ is ignored.
- FSM XFER:
  - Each cycle with beat_vld=1, beat_cnt increments (saturating).
  - beat_vld=1 with beat_eop=1 → IDLE the next cycle. That beat is counted.
  - beat_eop without beat_vld is ignored.
  - deq_ack and beat_vld in the same cycle while in REQ: the ack is taken; the beat is ignored and sets err_stray.
- Latency:
  - eligible asserted in IDLE cycle N → deq_req=1 in cycle N+1.
  - eop sampled in cycle M → state=IDLE in M+1 → next deq_req at the earliest in M+2.
- Strict mode:
  - Winner = highest-index eligible queue, unless some eligible queue has aging counter == starve_limit.
  - In that case, winner = highest-index queue among the starved eligible ones.
- Aging:
  - At each grant, the winner's counter resets to 0.
  - Every other eligible queue's counter increments, saturating at starve_limit.
  - Ineligible queues keep their counters.
  - Counters update in both modes.
- Round-robin mode:
  - Search eligible starting at rr_ptr, ascending and wrapping modulo num_of_priority. The first hit wins.
  - At grant, rr_ptr = winner+1 (wraps to 0).
  - rr_ptr is not updated in strict mode.
- err_stray: set when beat_vld=1 in IDLE or REQ. Cleared only by reset.

Test Plan:
- Strict, no contention: q_nonempty=ready=8'h04 → deq_req rises 1 cycle later with deq_pri=2. Ack, then 4 beats with eop on the 4th → beat_cnt=4, busy falls the cycle after eop.
- Strict ordering: eligible=8'h81, each packet 1 beat → grants 7,7,7… while q7 stays eligible. After 15 grants to 7, the 16th grant is 0 and counter[0] resets to 0.
- Round-robin: mode=1, eligible=8'hFF continuously, rr_ptr=0 → grants 0,1,2,…,7,0 in order.
- Request hold: in REQ, drop ready[deq_pri] and delay deq_ack 5 cycles → deq_req and deq_pri stay constant until the ack, then deq_req=0.
- Reset mid-XFER: after 2 beats, pulse rst_n low → deq_req=0, busy=0, beat_cnt=0 immediately (asynchronous). Return to IDLE and resume scheduling after rst_n rises.
- Stray beat: beat_vld=1 while in IDLE → err_stray=1 and stays 1 through later normal packets.
